muldiv_hilo: RTL and testbench

Iterative multiply/divide unit with the architectural HI/LO registers, in the execute stage directly downstream of the register file read ports. It consumes the two register-file operands (rs, rt) on MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds results in HI/LO for MFHI/MFLO. While an operation is in flight, busy stalls the pipeline.

---
 rtl/muldiv_hilo.sv | 201 ++++++++++++++++++++
 tb/tb_muldiv_hilo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Multiplies complete after MUL_LAT cycles, divides after 33 (32 steps + sign fixup).
module muldiv_hilo #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL     = 2'd1,
        DIV     = 2'd2,
        DIV_FIX = 2'd3
    } state_t;

    state_t      state_r, state_next_s;
    logic [5:0]  cnt_r;
    logic        accept_s, is_mul_s, is_div_s, div_signed_s;
    logic        busy_s, mul_wr_s, div_wr_s, mthi_s, mtlo_s;
    logic        mul_signed_r;
    logic [31:0] mul_a_r, mul_b_r;
    logic [31:0] rem_r, quo_r, dvsr_r, dividend_r;
    logic        neg_q_r, neg_r_r, div_zero_r;
    logic [63:0] product_s;
    logic [32:0] rem_shift_s, diff_s;
    logic [31:0] hi_r, lo_r;
    logic        done_r;

    function automatic logic [31:0] abs32(input logic [31:0] x, input logic sgn);
        if (sgn && x[31]) begin
            abs32 = 32'd0 - x;
        end else begin
            abs32 = x;
        end
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] x, input logic neg);
        if (neg) begin
            neg_if = 32'd0 - x;
        end else begin
            neg_if = x;
        end
    endfunction

    assign is_mul_s     = (op == 3'd0) || (op == 3'd1);
    assign is_div_s     = (op == 3'd2) || (op == 3'd3);
    assign div_signed_s = (op == 3'd2);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; cancel overrides both stepping and completion
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && !cancel && is_mul_s) begin
                    state_next_s = MUL;
                end else if (start && !cancel && is_div_s) begin
                    state_next_s = DIV;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL: begin
                if (cancel || (cnt_r == 6'd1)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = MUL;
                end
            end
            DIV: begin
                if (cancel) begin
                    state_next_s = IDLE;
                end else if (cnt_r == 6'd1) begin
                    state_next_s = DIV_FIX;
                end else begin
                    state_next_s = DIV;
                end
            end
            DIV_FIX: state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode: stall, result writes and move-to strobes
    always_comb begin
        busy_s   = (state_r != IDLE);
        accept_s = (state_r == IDLE) && start && !cancel;
        mul_wr_s = (state_r == MUL) && !cancel && (cnt_r == 6'd1);
        div_wr_s = (state_r == DIV_FIX) && !cancel;
        mthi_s   = accept_s && (op == 3'd4);
        mtlo_s   = accept_s && (op == 3'd5);
    end

    // Full-width product of the latched operands
    always_comb begin
        if (mul_signed_r) begin
            product_s = $signed({{32{mul_a_r[31]}}, mul_a_r}) * $signed({{32{mul_b_r[31]}}, mul_b_r});
        end else begin
            product_s = {32'd0, mul_a_r} * {32'd0, mul_b_r};
        end
    end

    assign rem_shift_s = {rem_r, quo_r[31]};
    assign diff_s      = rem_shift_s - {1'b0, dvsr_r};

    // Operand latch, cycle counter and restoring divide steps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r        <= 6'd0;
            mul_signed_r <= 1'b0;
            mul_a_r      <= 32'd0;
            mul_b_r      <= 32'd0;
            rem_r        <= 32'd0;
            quo_r        <= 32'd0;
            dvsr_r       <= 32'd0;
            dividend_r   <= 32'd0;
            neg_q_r      <= 1'b0;
            neg_r_r      <= 1'b0;
            div_zero_r   <= 1'b0;
        end else if (accept_s && is_mul_s) begin
            mul_a_r      <= a;
            mul_b_r      <= b;
            mul_signed_r <= (op == 3'd0);
            cnt_r        <= 6'(MUL_LAT);
        end else if (accept_s && is_div_s) begin
            dividend_r <= a;
            quo_r      <= abs32(a, div_signed_s);
            dvsr_r     <= abs32(b, div_signed_s);
            rem_r      <= 32'd0;
            neg_q_r    <= div_signed_s && (a[31] ^ b[31]);
            neg_r_r    <= div_signed_s && a[31];
            div_zero_r <= (b == 32'd0);
            cnt_r      <= 6'd32;
        end else if (state_r == MUL) begin
            cnt_r <= cnt_r - 6'd1;
        end else if (state_r == DIV) begin
            cnt_r <= cnt_r - 6'd1;
            if (!diff_s[32]) begin
                rem_r <= diff_s[31:0];
                quo_r <= {quo_r[30:0], 1'b1};
            end else begin
                rem_r <= rem_shift_s[31:0];
                quo_r <= {quo_r[30:0], 1'b0};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // HI/LO architectural registers and the completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            done_r <= 1'b0;
        end else begin
            done_r <= mul_wr_s || div_wr_s;
            if (mul_wr_s) begin
                hi_r <= product_s[63:32];
                lo_r <= product_s[31:0];
            end else if (div_wr_s && div_zero_r) begin
                hi_r <= dividend_r;
                lo_r <= 32'hFFFF_FFFF;
            end else if (div_wr_s) begin
                hi_r <= neg_if(rem_r, neg_r_r);
                lo_r <= neg_if(quo_r, neg_q_r);
            end else if (mthi_s) begin
                hi_r <= a;
            end else if (mtlo_s) begin
                lo_r <= a;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

    assign busy = busy_s;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: directed test-plan cases plus random ops,
// checked against a plain-arithmetic reference model.
module tb_muldiv_hilo;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst, start, cancel;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [63:0] exp_q[$];
    int          cyc_q[$];
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    muldiv_hilo #(.MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result {hi,lo} straight from the arithmetic definition
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sp;
        int     q, r;
        case (o)
            3'd0: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return sp;
            end
            3'd1: return {32'd0, x} * {32'd0, y};
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            3'd3: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drive one request (optionally waiting for a negedge first) and record the expectation
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit sync, input bit expect_done);
        logic [63:0] r;
        if (sync) @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        if (o <= 3'd3) begin
            if (expect_done) begin
                r = ref_result(o, x, y);
                exp_q.push_back(r);
                cyc_q.push_back(cyc + 1 + ((o <= 3'd1) ? LAT : 33));
                model_hi = r[63:32];
                model_lo = r[31:0];
            end
        end else if (o == 3'd4) begin
            model_hi = x;
        end else if (o == 3'd5) begin
            model_lo = x;
        end
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles, required 0", busy, n);
        end
    endtask

    // Monitor: every done pulse pops and checks value and arrival cycle
    initial begin
        logic        prev_done;
        logic [63:0] e;
        int          c;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (prev_done) chk("done_twice", 64'(prev_done && done), 64'd0);
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 64'(done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    chk("done_result", {hi, lo}, e);
                    chk("done_cycle", 64'(cyc), 64'(c));
                end
            end
            prev_done = done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got %0d checks", n_checks);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0]  o;
        logic [31:0] x, y;
        logic [63:0] exp;
        int          lat;
    } dir_t;

    initial begin
        dir_t dir[7];
        int   n;
        logic [2:0] ro;
        logic [31:0] rx, ry;

        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd7; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        rst = 1'b0;

        dir[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2,          64'hFFFF_FFFF_FFFF_FFFE, LAT};
        dir[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,          64'h0000_0001_FFFF_FFFE, LAT};
        dir[2] = '{3'd3, 32'd100,       32'd7,          64'h0000_0002_0000_000E, 33};
        dir[3] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          64'hFFFF_FFFF_FFFF_FFFD, 33};
        dir[4] = '{3'd2, 32'd7,         32'hFFFF_FFFE,  64'h0000_0001_FFFF_FFFD, 33};
        dir[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  64'h0000_0000_8000_0000, 33};
        dir[6] = '{3'd3, 32'h0000_1234, 32'd0,          64'h0000_1234_FFFF_FFFF, 33};
        foreach (dir[i]) begin
            issue(dir[i].o, dir[i].x, dir[i].y, 1'b1, 1'b1);
            wait_idle(n);
            chk($sformatf("dir%0d_busy_len", i), 64'(n), 64'(dir[i].lat));
            chk($sformatf("dir%0d_hilo", i), {hi, lo}, dir[i].exp);
            chk($sformatf("dir%0d_done", i), 64'(done), 64'd1);
        end

        // Move-to registers
        issue(3'd4, 32'hA5A5_A5A5, 32'd0, 1'b1, 1'b0);
        chk("mthi_hi", 64'(hi), 64'h0000_0000_A5A5_A5A5);
        chk("mthi_busy_done", {62'd0, busy, done}, 64'd0);
        issue(3'd5, 32'h5A5A_5A5A, 32'd0, 1'b1, 1'b0);
        chk("mtlo_hilo", {hi, lo}, 64'hA5A5_A5A5_5A5A_5A5A);
        chk("mtlo_busy_done", {62'd0, busy, done}, 64'd0);

        // Cancel mid-divide on cycle 10
        issue(3'd3, 32'd9, 32'd3, 1'b1, 1'b0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_hilo", {hi, lo}, 64'hA5A5_A5A5_5A5A_5A5A);

        // Cancel while idle blocks a same-cycle MTHI
        op = 3'd4; a = 32'h1111_1111; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("cancel_idle_mthi", {hi, lo}, 64'hA5A5_A5A5_5A5A_5A5A);
        repeat (40) @(negedge clk);

        // MTLO while busy is ignored
        issue(3'd0, 32'h1234_5678, 32'h0000_0010, 1'b1, 1'b1);
        op = 3'd5; a = 32'h0000_DEAD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        chk("busy_mtlo_ignored", {hi, lo}, 64'h0000_0001_2345_6780);

        // Back-to-back: DIVU accepted in the done cycle
        issue(3'd1, 32'd3, 32'd5, 1'b1, 1'b1);
        wait_idle(n);
        chk("b2b_done_cycle", 64'(done), 64'd1);
        issue(3'd3, 32'd1000, 32'd10, 1'b0, 1'b1);
        chk("b2b_accepted", 64'(busy), 64'd1);
        wait_idle(n);
        chk("b2b_result", {hi, lo}, 64'h0000_0000_0000_0064);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = rnd32();
            ry = rnd32();
            issue(ro, rx, ry, 1'b1, 1'b1);
            if (ro <= 3'd3) begin
                wait_idle(n);
                chk("rnd_busy_len", 64'(n), 64'((ro <= 3'd1) ? LAT : 33));
            end else begin
                chk("rnd_move_busy", 64'(busy), 64'd0);
            end
            chk("rnd_hilo", {hi, lo}, {model_hi, model_lo});
        end

        // Asynchronous reset in the middle of a divide
        issue(3'd2, 32'h0000_7FFF, 32'd3, 1'b1, 1'b0);
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_hilo", {hi, lo}, 64'd0);
        chk("arst_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("arst_after_hilo", {hi, lo}, 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
